// File: rtl/gpio_irq.sv
// gpio_irq: WIDTH-pin GPIO port with per-pin direction, set/clear and sticky edge IRQs.
// Define GPIO_IRQ_DEBOUNCE_EN to add a per-pin debounce filter after the synchroniser.
`timescale 1ns/1ps

module gpio_irq #(
  parameter int WIDTH        = 16,
  parameter int NBYTES       = WIDTH / 8,
  parameter int AW           = 3 + $clog2(NBYTES),
  parameter int DEBOUNCE_CYC = 255
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] AD,
  input  logic [7:0]    DI,
  output logic [7:0]    DO,
  input  logic          rw,
  input  logic          cs,
  inout  wire  [WIDTH-1:0] gpio,
  output logic          irq
);

  localparam int LW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [2:0] R_DATA = 3'd0;
  localparam logic [2:0] R_DIR  = 3'd1;
  localparam logic [2:0] R_MASK = 3'd2;
  localparam logic [2:0] R_POL  = 3'd3;
  localparam logic [2:0] R_BOTH = 3'd4;
  localparam logic [2:0] R_STAT = 3'd5;
  localparam logic [2:0] R_SET  = 3'd6;
  localparam logic [2:0] R_CLR  = 3'd7;

  if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_bad_width
    $error("gpio_irq: WIDTH must be 8, 16 or 32");
  end
  if (DEBOUNCE_CYC < 1 || DEBOUNCE_CYC > 65535) begin : g_bad_deb
    $error("gpio_irq: DEBOUNCE_CYC out of range");
  end

  logic [2:0]       sel;
  logic [LW-1:0]    lane;
  logic             we;
  int               sh;
  logic [WIDTH-1:0] lmask;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic [WIDTH-1:0] rv;
  logic [WIDTH-1:0] rsh;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev;

  logic [WIDTH-1:0] out_q,  out_d;
  logic [WIDTH-1:0] dir_q,  dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] pol_q,  pol_d;
  logic [WIDTH-1:0] both_q, both_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] s1_q,   s1_d;
  logic [WIDTH-1:0] s2_q,   s2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             irq_q,  irq_d;

  assign sel   = AD[AW-1:AW-3];
  assign we    = cs & ~rw;
  assign wdata = {NBYTES{DI}};

  if (NBYTES > 1) begin : g_lane
    assign lane = AD[AW-4:0];
  end else begin : g_lane1
    assign lane = '0;
  end

  // Lane 0 is the most significant byte.
  always_comb begin
    sh    = (NBYTES - 1 - int'(lane)) * 8;
    lmask = WIDTH'(8'hFF) << sh;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_pad
    assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
  end

`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic [15:0]      cnt_q [WIDTH];
  logic [15:0]      cnt_d [WIDTH];
  logic [WIDTH-1:0] deb_q, deb_d;

  // A pin's filtered value follows only after a full run of differing samples.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == 16'(DEBOUNCE_CYC - 1)) begin
          deb_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      deb_q <= deb_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign din = deb_q;
`else
  assign din = s2_q;
`endif

  assign rise = din & ~prev_q;
  assign fall = ~din & prev_q;
  assign ev   = (both_q & (rise | fall))
              | (~both_q & pol_q & rise)
              | (~both_q & ~pol_q & fall);

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    pol_d  = pol_q;
    both_d = both_q;
    clr    = '0;
    if (we) begin
      unique case (1'b1)
        (sel == R_DATA): out_d  = (out_q & ~lmask) | (wdata & lmask);
        (sel == R_DIR):  dir_d  = (dir_q & ~lmask) | (wdata & lmask);
        (sel == R_MASK): mask_d = (mask_q & ~lmask) | (wdata & lmask);
        (sel == R_POL):  pol_d  = (pol_q & ~lmask) | (wdata & lmask);
        (sel == R_BOTH): both_d = (both_q & ~lmask) | (wdata & lmask);
        (sel == R_STAT): clr    = wdata & lmask;
        (sel == R_SET):  out_d  = out_q | (wdata & lmask);
        (sel == R_CLR):  out_d  = out_q & ~(wdata & lmask);
        default: ;
      endcase
    end
    // A new event beats a simultaneous write-1-to-clear.
    stat_d = ev | (stat_q & ~clr);
    irq_d  = |(stat_q & mask_q);
    s1_d   = gpio;
    s2_d   = s1_q;
    prev_d = din;
  end

  always_comb begin
    rv = '0;
    unique case (1'b1)
      (sel == R_DATA): rv = (din & ~dir_q) | (out_q & dir_q);
      (sel == R_DIR):  rv = dir_q;
      (sel == R_MASK): rv = mask_q;
      (sel == R_POL):  rv = pol_q;
      (sel == R_BOTH): rv = both_q;
      (sel == R_STAT): rv = stat_q;
      default:         rv = '0;
    endcase
    rsh = rv >> sh;
    DO  = rsh[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= '0;
      dir_q  <= '0;
      mask_q <= '0;
      pol_q  <= '0;
      both_q <= '0;
      stat_q <= '0;
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      pol_q  <= pol_d;
      both_q <= both_d;
      stat_q <= stat_d;
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      irq_q  <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_gpio_irq.sv
// tb_gpio_irq: directed bench for gpio_irq with a cycle model and per-cycle compare.
// Pad, register and interrupt behaviour checked at WIDTH=16.
`timescale 1ns/1ps

module tb_gpio_irq;

  localparam int W  = 16;
  localparam int NB = 2;
  localparam int AW = 4;
`ifdef GPIO_IRQ_DEBOUNCE_EN
  localparam int DCYC = 4;
  localparam int DLY  = 4;
`else
  localparam int DCYC = 255;
  localparam int DLY  = 0;
`endif

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] AD    = '0;
  logic [7:0]    DI    = '0;
  logic          rw    = 1'b1;
  logic          cs    = 1'b0;
  wire  [7:0]    DO;
  wire           irq;
  wire  [W-1:0]  gpio;
  logic [W-1:0]  tb_en  = '1;
  logic [W-1:0]  tb_val = '0;

  int checks = 0;
  int errors = 0;

  for (genvar i = 0; i < W; i++) begin : g_drv
    assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  gpio_irq #(.WIDTH(W), .DEBOUNCE_CYC(DCYC)) dut (
    .clk(clk), .rst_n(rst_n), .AD(AD), .DI(DI), .DO(DO),
    .rw(rw), .cs(cs), .gpio(gpio), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register file plus a delay line for the pad samples.
  logic [W-1:0] m_out, m_dir, m_mask, m_pol, m_both, m_stat;
  logic [W-1:0] m_in, m_prev, m_pad1, m_sync;
  logic         m_irq;
  logic [W-1:0] t_pad, t_ev, t_clr, t_wd;
  logic         t_irq;
`ifdef GPIO_IRQ_DEBOUNCE_EN
  logic [W-1:0] m_deb;
  logic [W-1:0] hist[$];
`endif

  function automatic logic [7:0] model_do(input logic [AW-1:0] a);
    logic [W-1:0] r;
    case (a[3:1])
      3'd0:    r = (m_in & ~m_dir) | (m_out & m_dir);
      3'd1:    r = m_dir;
      3'd2:    r = m_mask;
      3'd3:    r = m_pol;
      3'd4:    r = m_both;
      3'd5:    r = m_stat;
      default: r = '0;
    endcase
    return 8'(r >> ((NB - 1 - int'(a[0])) * 8));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = '0; m_dir = '0; m_mask = '0; m_pol = '0; m_both = '0;
      m_stat = '0; m_in = '0; m_prev = '0; m_pad1 = '0; m_sync = '0;
      m_irq = 1'b0;
`ifdef GPIO_IRQ_DEBOUNCE_EN
      m_deb = '0;
      hist.delete();
`endif
    end else begin
      t_pad = (m_out & m_dir) | (tb_val & tb_en & ~m_dir);
      t_ev  = '0;
      for (int i = 0; i < W; i++) begin
        if (m_in[i] != m_prev[i] && (m_both[i] || m_pol[i] == m_in[i]))
          t_ev[i] = 1'b1;
      end
      t_irq = |(m_stat & m_mask);
      t_clr = '0;
      if (cs && !rw) begin
        t_wd = ({NB{DI}}) & (W'(8'hFF) << ((NB - 1 - int'(AD[0])) * 8));
        case (AD[3:1])
          3'd0: m_out  = (m_out & ~(W'(8'hFF) << ((NB - 1 - int'(AD[0])) * 8))) | t_wd;
          3'd1: m_dir  = (m_dir & ~(W'(8'hFF) << ((NB - 1 - int'(AD[0])) * 8))) | t_wd;
          3'd2: m_mask = (m_mask & ~(W'(8'hFF) << ((NB - 1 - int'(AD[0])) * 8))) | t_wd;
          3'd3: m_pol  = (m_pol & ~(W'(8'hFF) << ((NB - 1 - int'(AD[0])) * 8))) | t_wd;
          3'd4: m_both = (m_both & ~(W'(8'hFF) << ((NB - 1 - int'(AD[0])) * 8))) | t_wd;
          3'd5: t_clr  = t_wd;
          3'd6: m_out  = m_out | t_wd;
          default: m_out = m_out & ~t_wd;
        endcase
      end
      m_stat = (m_stat & ~t_clr) | t_ev;
      m_irq  = t_irq;
      m_prev = m_in;
`ifdef GPIO_IRQ_DEBOUNCE_EN
      hist.push_back(m_sync);
      if (hist.size() > DCYC) void'(hist.pop_front());
      if (hist.size() == DCYC) begin
        for (int i = 0; i < W; i++) begin
          bit all_diff;
          all_diff = 1'b1;
          foreach (hist[k]) if (hist[k][i] == m_deb[i]) all_diff = 1'b0;
          if (all_diff) m_deb[i] = ~m_deb[i];
        end
      end
      m_in = m_deb;
`else
      m_in = m_pad1;
`endif
      m_sync = m_pad1;
      m_pad1 = t_pad;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("do_model", DO, model_do(AD));
      chk("irq_model", irq, m_irq);
      chk("pads_model", gpio & m_dir, m_out & m_dir);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] sel, input logic ln,
                    input logic [7:0] d);
    AD = {sel, ln};
    DI = d;
    cs = 1'b1;
    rw = 1'b0;
    tick();
    cs = 1'b0;
    rw = 1'b1;
  endtask

  task automatic rd(input logic [2:0] sel, input logic ln,
                    input logic [7:0] exp, input string name);
    AD = {sel, ln};
    @(negedge clk);
    chk(name, DO, exp);
  endtask

  initial begin
    repeat (3) tick();
    AD = '0;
    @(negedge clk);
    chk("rst_irq", irq, 1'b0);
    chk("rst_do", DO, 8'h00);
    tick();
    rst_n = 1'b1;
    tick();

    // Upper byte as output carrying 0xA5
    wr(3'd1, 1'b0, 8'hFF);
    tb_en[15:8] = '0;
    wr(3'd0, 1'b0, 8'hA5);
    rd(3'd0, 1'b0, 8'hA5, "data_l0");
    chk("pad_hi", gpio[15:8], 8'hA5);

    // Synchroniser latency on the input lane
    tick();
    tb_val[7:0] = 8'h3C;
`ifndef GPIO_IRQ_DEBOUNCE_EN
    rd(3'd0, 1'b1, 8'h00, "sync_lat0");
    tick();
    rd(3'd0, 1'b1, 8'h00, "sync_lat1");
    tick();
`else
    repeat (DLY + 2) tick();
`endif
    rd(3'd0, 1'b1, 8'h3C, "sync_lat2");

    // SET / CLR on the low lane as outputs
    wr(3'd0, 1'b1, 8'h3C);
    wr(3'd1, 1'b1, 8'hFF);
    tb_en[7:0] = '0;
    wr(3'd0, 1'b1, 8'hF0);
    wr(3'd6, 1'b1, 8'h0F);
    wr(3'd7, 1'b1, 8'h30);
    rd(3'd0, 1'b1, 8'hCF, "setclr_l1");
    rd(3'd0, 1'b0, 8'hA5, "setclr_l0");
    chk("pad_lo", gpio[7:0], 8'hCF);
    AD = {3'd0, 1'b1}; DI = 8'h00; cs = 1'b1; rw = 1'b1;
    tick();
    cs = 1'b0; rw = 1'b0;
    tick();
    rw = 1'b1;
    rd(3'd0, 1'b1, 8'hCF, "no_write");

    // Rising-edge interrupt on bit 0
    wr(3'd0, 1'b1, 8'h00);
    wr(3'd1, 1'b1, 8'h00);
    tb_en[7:0] = '1;
    tb_val[7:0] = '0;
    repeat (8 + DLY) tick();
    wr(3'd5, 1'b0, 8'hFF);
    wr(3'd5, 1'b1, 8'hFF);
    wr(3'd2, 1'b1, 8'h01);
    wr(3'd3, 1'b1, 8'h01);
    rd(3'd5, 1'b1, 8'h00, "stat_clr");
    tick();
    tb_val[0] = 1'b1;
`ifndef GPIO_IRQ_DEBOUNCE_EN
    tick();
    tick();
    rd(3'd5, 1'b1, 8'h00, "stat_e2");
    chk("irq_e2", irq, 1'b0);
    tick();
    rd(3'd5, 1'b1, 8'h01, "stat_e3");
    chk("irq_e3", irq, 1'b0);
    tick();
    @(negedge clk);
    chk("irq_e4", irq, 1'b1);
`else
    repeat (4 + DLY) tick();
    rd(3'd5, 1'b1, 8'h01, "stat_e3");
    chk("irq_e4", irq, 1'b1);
`endif
    tick();
    tb_val[0] = 1'b0;
    repeat (5 + DLY) tick();
    rd(3'd5, 1'b1, 8'h01, "stat_fall");
    wr(3'd5, 1'b1, 8'h01);
    @(negedge clk);
    chk("irq_w1c0", irq, 1'b1);
    tick();
    @(negedge clk);
    chk("irq_w1c1", irq, 1'b0);
    rd(3'd5, 1'b1, 8'h00, "stat_w1c");

    // Event and W1C on bit 3 in the same cycle
    wr(3'd4, 1'b1, 8'h08);
    tick();
    tb_val[3] = 1'b1;
    repeat (2 + DLY) tick();
    wr(3'd5, 1'b1, 8'h08);
    rd(3'd5, 1'b1, 8'h08, "stat_race");
    tick();
    tb_val[3] = 1'b0;
    repeat (5 + DLY) tick();
    wr(3'd5, 1'b1, 8'h08);
    rd(3'd5, 1'b1, 8'h00, "stat_w1c3");

`ifdef GPIO_IRQ_DEBOUNCE_EN
    wr(3'd3, 1'b1, 8'h05);
    tick();
    tb_val[2] = 1'b1;
    repeat (3) tick();
    tb_val[2] = 1'b0;
    repeat (10) tick();
    rd(3'd5, 1'b1, 8'h00, "deb_glitch");
    rd(3'd0, 1'b1, 8'h00, "deb_data");
    tick();
    tb_val[2] = 1'b1;
    repeat (6) tick();
    tb_val[2] = 1'b0;
    repeat (10) tick();
    rd(3'd5, 1'b1, 8'h04, "deb_pulse");
`endif

    // Asynchronous reset in the middle of a write
    tick();
    tb_val[0] = 1'b1;
    repeat (5 + DLY) tick();
    @(negedge clk);
    chk("irq_pre_rst", irq, 1'b1);
    wr(3'd0, 1'b1, 8'h01);
    wr(3'd1, 1'b1, 8'hFF);
    tb_en = '0;
    wr(3'd6, 1'b0, 8'hFF);
    wr(3'd6, 1'b1, 8'hFF);
    AD = {3'd7, 1'b0}; DI = 8'hFF; cs = 1'b1; rw = 1'b0;
    #2;
    rst_n  = 1'b0;
    tb_val = '0;
    tb_en  = '1;
    #1;
    chk("rst_irq_async", irq, 1'b0);
    chk("rst_pads", gpio, 16'h0000);
    cs = 1'b0; rw = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4 + DLY) tick();
    rd(3'd1, 1'b0, 8'h00, "rst_dir0");
    rd(3'd1, 1'b1, 8'h00, "rst_dir1");
    rd(3'd2, 1'b1, 8'h00, "rst_mask");
    rd(3'd5, 1'b1, 8'h00, "rst_stat");
    rd(3'd0, 1'b0, 8'h00, "rst_data");
    chk("rst_irq_after", irq, 1'b0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
